// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake, register-file read port,
// issued-operation handshake and the status outputs of alu_issue.
interface alu_issue_if #(
    parameter int DATA_W = 16
);
    // Instruction side
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;

    // Register-file read port
    logic [3:0]        rs_addr;
    logic [3:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    // Issued operation
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        rd;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;

    // Flags and status
    logic [2:0]        alu_flags;
    logic [2:0]        flags_q;
    logic [15:0]       issue_cnt;
    logic              unsupported;
    logic              halted;

    // The issue block itself
    modport slave (
        input  instr_valid, instr, rs_data, rt_data, ex_ready, alu_flags,
        output instr_ready, rs_addr, rt_addr, ex_valid, alu_op, alu_a, alu_b,
               rd, reg_we, mem_re, mem_we, flags_q, issue_cnt, unsupported,
               halted
    );

    // Environment: fetch, register file and execute stage
    modport master (
        output instr_valid, instr, rs_data, rt_data, ex_ready, alu_flags,
        input  instr_ready, rs_addr, rt_addr, ex_valid, alu_op, alu_a, alu_b,
               rd, reg_we, mem_re, mem_we, flags_q, issue_cnt, unsupported,
               halted
    );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one 16-bit instruction per accept, reads the
// register file combinationally and presents the operation to the execute
// stage one cycle later behind a valid/ready handshake. Also keeps the
// {Z,V,N} flag register, a saturating issue counter and halt state.
module alu_issue #(
    parameter int DATA_W = 16
) (
    input logic       clk,
    input logic       rst,
    alu_issue_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_RED = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_PAD = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Word offset for LW/SW: sign-extended 4-bit immediate times two.
    function automatic logic signed [DATA_W-1:0] mem_off(input logic [3:0] imm);
        logic signed [3:0]        imm_s;
        logic signed [DATA_W-1:0] ext;
        imm_s = signed'(imm);
        ext   = {{(DATA_W-4){imm_s[3]}}, imm_s};
        return ext <<< 1;
    endfunction

    // Completion counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Flag update for a completing op: arithmetic loads all, logic/shift Z only.
    function automatic logic [2:0] flags_upd(input logic [3:0] op,
                                             input logic [2:0] cur,
                                             input logic [2:0] alu);
        logic [2:0] nxt;
        nxt = cur;
        case (op)
            OP_ADD, OP_SUB:                 nxt = alu;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: nxt[2] = alu[2];
            default:                        nxt = cur;
        endcase
        return nxt;
    endfunction

    // ---- p0: combinational decode of the offered instruction ----
    logic [3:0]        op_p0;
    logic [3:0]        f1_p0;
    logic [3:0]        f2_p0;
    logic [3:0]        f3_p0;
    logic              ldhb_p0;
    logic              issue_p0;
    logic              hlt_p0;
    logic              unsup_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [3:0]        rd_p0;
    logic              we_p0;
    logic              re_p0;
    logic              mwe_p0;

    logic vld_p1;
    logic accept;
    logic complete;

    assign op_p0    = bus.instr[15:12];
    assign f1_p0    = bus.instr[11:8];
    assign f2_p0    = bus.instr[7:4];
    assign f3_p0    = bus.instr[3:0];
    assign ldhb_p0  = (op_p0 == OP_LLB) || (op_p0 == OP_LHB);
    assign issue_p0 = (op_p0[3:2] != 2'b11);
    assign hlt_p0   = (op_p0 == OP_HLT);
    assign unsup_p0 = (op_p0[3:2] == 2'b11) && !hlt_p0;

    // LLB/LHB read the destination register as their source operand.
    assign bus.rs_addr = ldhb_p0 ? f1_p0 : f2_p0;
    // SW reads its store data register from the f1 field.
    assign bus.rt_addr = (op_p0 == OP_SW) ? f1_p0 : f3_p0;

    assign vld_p1          = (state == ST_HOLD);
    assign bus.instr_ready = (!vld_p1 || bus.ex_ready) && (state != ST_HALT);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign complete        = vld_p1 && bus.ex_ready;

    // Operand and control selection per opcode class
    always_comb begin
        a_p0   = bus.rs_data;
        b_p0   = '0;
        rd_p0  = f1_p0;
        we_p0  = 1'b0;
        re_p0  = 1'b0;
        mwe_p0 = 1'b0;
        case (op_p0)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PAD: begin
                b_p0  = bus.rt_data;
                we_p0 = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                b_p0  = {{(DATA_W-4){1'b0}}, f3_p0};
                we_p0 = 1'b1;
            end
            OP_LW: begin
                b_p0  = mem_off(f3_p0);
                we_p0 = 1'b1;
                re_p0 = 1'b1;
            end
            OP_SW: begin
                b_p0   = mem_off(f3_p0);
                mwe_p0 = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                b_p0  = {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
                we_p0 = 1'b1;
            end
            default: begin
                a_p0 = bus.rs_data;
            end
        endcase
    end

    // Next-state: accept decides what follows, else completion drains HOLD
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN, ST_HOLD: begin
                if (accept) begin
                    if (hlt_p0) begin
                        state_nxt = ST_HALT;
                    end else if (issue_p0) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end else if (complete) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- p1: registered issued operation ----
    logic [3:0]        alu_op_p1;
    logic [DATA_W-1:0] alu_a_p1;
    logic [DATA_W-1:0] alu_b_p1;
    logic [3:0]        rd_p1;
    logic              we_p1;
    logic              re_p1;
    logic              mwe_p1;
    logic              unsup_p1;
    logic [2:0]        flags_p1;
    logic [15:0]       cnt_p1;

    // Operation register: load on issuing accept, drop strobes when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_p1 <= '0;
            alu_a_p1  <= '0;
            alu_b_p1  <= '0;
            rd_p1     <= '0;
            we_p1     <= 1'b0;
            re_p1     <= 1'b0;
            mwe_p1    <= 1'b0;
        end else if (accept && issue_p0) begin
            alu_op_p1 <= op_p0;
            alu_a_p1  <= a_p0;
            alu_b_p1  <= b_p0;
            rd_p1     <= rd_p0;
            we_p1     <= we_p0;
            re_p1     <= re_p0;
            mwe_p1    <= mwe_p0;
        end else if (complete) begin
            we_p1     <= 1'b0;
            re_p1     <= 1'b0;
            mwe_p1    <= 1'b0;
        end
    end

    // One-cycle pulse after an unsupported opcode is swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            unsup_p1 <= 1'b0;
        end else begin
            unsup_p1 <= accept && unsup_p0;
        end
    end

    // Flags and completion count advance when the execute stage takes an op
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_p1 <= 3'b000;
            cnt_p1   <= '0;
        end else if (complete) begin
            flags_p1 <= flags_upd(alu_op_p1, flags_p1, bus.alu_flags);
            cnt_p1   <= sat_inc(cnt_p1);
        end
    end

    assign bus.ex_valid    = vld_p1;
    assign bus.alu_op      = alu_op_p1;
    assign bus.alu_a       = alu_a_p1;
    assign bus.alu_b       = alu_b_p1;
    assign bus.rd          = rd_p1;
    assign bus.reg_we      = we_p1;
    assign bus.mem_re      = re_p1;
    assign bus.mem_we      = mwe_p1;
    assign bus.flags_q     = flags_p1;
    assign bus.issue_cnt   = cnt_p1;
    assign bus.unsupported = unsup_p1;
    assign bus.halted      = (state == ST_HALT);

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed scenarios plus randomized traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_alu_issue;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file seen by the block
    logic [15:0] rf [16];
    assign bus.rs_data = rf[bus.rs_addr];
    assign bus.rt_data = rf[bus.rt_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          m_valid, m_halted, m_unsup, m_we, m_re, m_mwe;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_a, m_b, m_cnt;
    logic [2:0]  m_flags;

    task automatic model_reset();
        m_valid  = 0; m_halted = 0; m_unsup = 0;
        m_we = 0; m_re = 0; m_mwe = 0;
        m_op = 0; m_rd = 0; m_a = 0; m_b = 0;
        m_cnt = 0; m_flags = 3'b000;
    endtask

    // One clock: drive inputs, check combinational outputs, advance model,
    // clock the DUT, check registered outputs.
    task automatic cycle(input bit v, input logic [15:0] ins, input bit rdy,
                         input logic [2:0] fl, input bit r);
        bit         exp_rdy, acc, done;
        logic [3:0] op, ers, ert;
        int         off;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.ex_ready    = rdy;
        bus.alu_flags   = fl;
        rst             = r;
        #1;
        op      = ins[15:12];
        ers     = (op == 4'hA || op == 4'hB) ? ins[11:8] : ins[7:4];
        ert     = (op == 4'h9) ? ins[11:8] : ins[3:0];
        exp_rdy = !m_halted && (!m_valid || rdy);
        check("instr_ready", bus.instr_ready, exp_rdy);
        check("rs_addr", bus.rs_addr, ers);
        check("rt_addr", bus.rt_addr, ert);
        acc  = v && exp_rdy;
        done = m_valid && rdy;
        if (r) begin
            model_reset();
        end else begin
            if (done) begin
                if (m_op == 4'h0 || m_op == 4'h1) m_flags = fl;
                else if (m_op inside {4'h2, 4'h4, 4'h5, 4'h6}) m_flags[2] = fl[2];
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
            m_unsup = acc && (op inside {4'hC, 4'hD, 4'hE});
            if (acc && op == 4'hF) m_halted = 1;
            if (acc && op < 4'hC) begin
                m_valid = 1;
                m_op    = op;
                m_rd    = ins[11:8];
                m_a     = rf[ers];
                m_we    = (op != 4'h9);
                m_re    = (op == 4'h8);
                m_mwe   = (op == 4'h9);
                if (op < 4'h4 || op == 4'h7) begin
                    m_b = rf[ert];
                end else if (op < 4'h8) begin
                    m_b = {12'h000, ins[3:0]};
                end else if (op < 4'hA) begin
                    off = $signed(ins[3:0]);
                    m_b = 16'(off * 2);
                end else begin
                    m_b = {8'h00, ins[7:0]};
                end
            end else if (done) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check("ex_valid", bus.ex_valid, m_valid);
        check("halted", bus.halted, m_halted);
        check("unsupported", bus.unsupported, m_unsup);
        check("flags_q", bus.flags_q, m_flags);
        check("issue_cnt", bus.issue_cnt, m_cnt);
        if (m_valid || r) begin
            check("alu_op", bus.alu_op, m_op);
            check("alu_a", bus.alu_a, m_a);
            check("alu_b", bus.alu_b, m_b);
            check("rd", bus.rd, m_rd);
            check("reg_we", bus.reg_we, m_we);
            check("mem_re", bus.mem_re, m_re);
            check("mem_we", bus.mem_we, m_mwe);
        end
    endtask

    function automatic logic [15:0] rand_rtype();
        logic [3:0] ops [5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'h7;
        return {ops[$urandom_range(4)], 12'($urandom)};
    endfunction

    initial begin
        logic [15:0] cnt_prev;
        logic [15:0] ins;
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        rf[1] = 16'h0F0F;
        rf[2] = 16'h1234;
        rf[3] = 16'h4321;

        // Raw reset, then reset-state checks
        bus.instr_valid = 0; bus.instr = 0; bus.ex_ready = 0; bus.alu_flags = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        #1;
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_flags", bus.flags_q, 0);
        check("rst_cnt", bus.issue_cnt, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_reg_we", bus.reg_we, 0);

        // ADD, SLL, LW, LLB back to back
        cycle(1, 16'h0123, 1, 3'b000, 0);
        check("add_valid", bus.ex_valid, 1);
        check("add_op", bus.alu_op, 4'h0);
        check("add_a", bus.alu_a, 16'h1234);
        check("add_b", bus.alu_b, 16'h4321);
        check("add_rd", bus.rd, 4'h1);
        check("add_we", bus.reg_we, 1);
        cycle(1, 16'h4125, 1, 3'b000, 0);
        check("sll_b", bus.alu_b, 16'h0005);
        cycle(1, 16'h812E, 1, 3'b000, 0);
        check("lw_b", bus.alu_b, 16'hFFFC);
        check("lw_re", bus.mem_re, 1);
        check("lw_rd", bus.rd, 4'h1);
        cycle(1, 16'hA359, 1, 3'b000, 0);
        check("llb_rs_addr", bus.rs_addr, 4'h3);
        check("llb_a", bus.alu_a, 16'h4321);
        check("llb_b", bus.alu_b, 16'h0059);
        check("llb_rd", bus.rd, 4'h3);
        cycle(0, 16'h0000, 1, 3'b000, 0);

        // Backpressure: held output, then back-to-back issue
        cycle(1, 16'h0123, 1, 3'b000, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, rand_rtype(), 0, 3'($urandom), 0);
            check("bp_hold_a", bus.alu_a, 16'h1234);
            check("bp_hold_b", bus.alu_b, 16'h4321);
        end
        for (int i = 0; i < 4; i++) begin
            cnt_prev = bus.issue_cnt;
            cycle(1, rand_rtype(), 1, 3'b000, 0);
            check("b2b_cnt", bus.issue_cnt, cnt_prev + 16'd1);
            check("b2b_valid", bus.ex_valid, 1);
        end
        cycle(0, 16'h0000, 1, 3'b000, 0);

        // Flag updates: ADD all, XOR Z only, LLB none
        cycle(1, 16'h0123, 1, 3'b000, 0);
        cycle(1, 16'h2456, 1, 3'b110, 0);
        check("flags_add", bus.flags_q, 3'b110);
        cycle(1, 16'hA359, 1, 3'b011, 0);
        check("flags_xor", bus.flags_q, 3'b010);
        cycle(0, 16'h0000, 1, 3'b111, 0);
        check("flags_llb", bus.flags_q, 3'b010);

        // Unsupported opcode pulse
        cycle(1, 16'hC123, 1, 3'b000, 0);
        check("unsup_pulse", bus.unsupported, 1);
        check("unsup_novalid", bus.ex_valid, 0);
        cycle(0, 16'h0000, 1, 3'b000, 0);
        check("unsup_clear", bus.unsupported, 0);

        // HLT holds the block until reset
        cycle(1, 16'hF000, 1, 3'b000, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 16'($urandom), 1, 3'($urandom), 0);
            check("hlt_halted", bus.halted, 1);
            check("hlt_ready", bus.instr_ready, 0);
        end
        cycle(0, 16'h0000, 0, 3'b000, 1);
        check("hlt_rst_halted", bus.halted, 0);
        check("hlt_rst_ready", bus.instr_ready, 1);

        // HLT accepted while an ADD completes
        cycle(1, 16'h0123, 1, 3'b000, 0);
        cycle(1, 16'hF000, 1, 3'b101, 0);
        check("hltc_flags", bus.flags_q, 3'b101);
        check("hltc_cnt", bus.issue_cnt, 16'd1);
        check("hltc_halted", bus.halted, 1);
        cycle(0, 16'h0000, 0, 3'b000, 1);

        // Reset during HOLD discards the operation
        cycle(1, 16'h0123, 1, 3'b000, 0);
        cycle(0, 16'h0000, 0, 3'b000, 0);
        cycle(0, 16'h0000, 0, 3'b111, 1);
        check("rsthold_valid", bus.ex_valid, 0);
        check("rsthold_cnt", bus.issue_cnt, 0);
        check("rsthold_flags", bus.flags_q, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) rf[$urandom_range(15)] = 16'($urandom);
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF && $urandom_range(3) != 0) ins[15:12] = 4'h0;
            cycle(($urandom_range(3) != 0), ins, ($urandom_range(2) != 0),
                  3'($urandom), ($urandom_range(59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  instruction accepted when high with instr_valid.
- instr  in  16  {opcode[15:12], f1[11:8], f2[7:4], f3[3:0]}.
- rs_addr  out  4  combinational register-file read address; instr[11:8] for LLB/LHB, else instr[7:4].
- rt_addr  out  4  combinational; instr[11:8] for SW, else instr[3:0].
- rs_data, rt_data  in  16 each  register-file read data for rs_addr/rt_addr, same cycle.
- ex_valid  out  1  issued operation valid.
- ex_ready  in  1  downstream accepts the issued operation.
- alu_op  out  4  ALU opcode.
- alu_a, alu_b  out  16 each  ALU operands.
- rd  out  4  destination register.
- reg_we, mem_re, mem_we  out  1 each  write-back, load and store controls.
- alu_flags  in  3  ALU {Z,V,N} for the currently issued operation.
- flags_q  out  3  flag register {Z,V,N}.
- issue_cnt  out  16  count of completed issues.
- unsupported  out  1  one-cycle pulse when opcode 1100/1101/1110 is accepted.
- halted  out  1  HLT seen.

Function
REQ-003 The block SHALL have three states: RUN (output register empty), HOLD (ex_valid=1) and HALT.
REQ-004 instr_ready SHALL be (!ex_valid || ex_ready) && !halted.
REQ-005 On accept (instr_valid && instr_ready), the decoded fields SHALL be registered and ex_valid SHALL be 1 on the next cycle, giving one-cycle latency.
REQ-006 Opcodes 0000-1011 SHALL issue with alu_op = opcode.
REQ-007 Opcodes 0000, 0001, 0010, 0011 and 0111 (R-type) SHALL issue a=rs_data, b=rt_data, rd=instr[11:8], reg_we=1.
REQ-008 Opcodes 0100, 0101 and 0110 (shift/rotate) SHALL issue a=rs_data, b={12'h000, instr[3:0]}, rd=instr[11:8], reg_we=1.
REQ-009 LW (1000) SHALL issue a=rs_data, b=sign-extended instr[3:0] shifted left 1 (16-bit), rd=instr[11:8], reg_we=1, mem_re=1.
REQ-010 SW (1001) SHALL issue the same operands as LW, with mem_we=1, reg_we=0; the store data path is outside this block.
REQ-011 LLB (1010) and LHB (1011) SHALL issue a=rs_data (register instr[11:8]), b={8'h00, instr[7:0]}, rd=instr[11:8], reg_we=1.
REQ-012 Opcodes 1100, 1101 and 1110 SHALL be accepted without setting ex_valid, and SHALL pulse unsupported for the cycle after accept.
REQ-013 HLT (1111) SHALL be accepted without setting ex_valid, SHALL drive halted=1 from the next cycle, and SHALL force instr_ready=0 until reset.
REQ-014 An issue SHALL complete on ex_valid && ex_ready. If an accept occurs in the same cycle, new values SHALL load and ex_valid SHALL remain 1; otherwise ex_valid SHALL clear.
REQ-015 While ex_valid && !ex_ready, every ex_* output SHALL hold stable.
REQ-016 At issue completion, flags_q SHALL update on the next edge:
- ADD/SUB: Z, V, N all load from alu_flags.
- XOR/SLL/SRA/ROR: Z only loads; V and N hold.
- all other ops: no flag change.
REQ-017 issue_cnt SHALL increment by 1 per issue completion and SHALL saturate at 16'hFFFF.
REQ-018 If HLT is accepted while a prior issue completes in the same cycle, that issue SHALL complete normally, including its flag and counter updates.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL set:
- state RUN.
- ex_valid, reg_we, mem_re, mem_we, unsupported and halted to 0.
- alu_op, alu_a, alu_b and rd to 0.
- flags_q to 3'b000 and issue_cnt to 0.
REQ-020 Reset SHALL take priority over all events, including a pending HOLD or HALT; an in-flight operation is discarded.
REQ-021 instr_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD: instr=16'h0123, rs_data=16'h1234, rt_data=16'h4321 -> next cycle ex_valid=1, alu_op=0000, a=16'h1234, b=16'h4321, rd=1, reg_we=1.
- SLL: instr=16'h4125 -> b=16'h0005. LW: instr=16'h812E -> b=16'hFFFC, mem_re=1, rd=1. LLB: instr=16'hA359 -> rs_addr=3, b=16'h0059, rd=3.
- Backpressure: ex_ready=0 for 3 cycles -> instr_ready=0 and ex_* outputs stable; ex_ready=1 with instr_valid=1 -> back-to-back issue, issue_cnt +1 per cycle.
- Flags: ADD completes with alu_flags=3'b110 -> flags_q=3'b110; then XOR completes with alu_flags=3'b011 -> flags_q=3'b010; then LLB completes -> flags_q=3'b010.
- HLT: instr=16'hF000 accepted -> halted=1, instr_ready=0 for 10 cycles, ex_valid=0; rst=1 -> halted=0, instr_ready=1.
- Reset mid-HOLD: ex_valid=1, ex_ready=0, rst=1 -> ex_valid=0 next cycle, with issue_cnt and flags_q unchanged from reset values (0).
